// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Opcode/func values match the main decoder; the control vector type bundles
// the four pipeline-register controls so each output case is one constant.
package pipeline_hazard_ctrl_pkg;

  localparam logic [5:0] OpRtype = 6'd0;
  localparam logic [5:0] OpJ     = 6'd2;
  localparam logic [5:0] OpJal   = 6'd3;
  localparam logic [5:0] OpBeq   = 6'd4;
  localparam logic [5:0] OpBne   = 6'd5;
  localparam logic [5:0] OpSw    = 6'd43;
  localparam logic [5:0] OpStop  = 6'd63;
  localparam logic [5:0] FuncJr  = 6'd8;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StDrain = 2'd1,
    StHalt  = 2'd2
  } state_e;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_flush;
  } ctrl_t;

  // Normal advance.
  localparam ctrl_t CtrlRun    = 4'b1100;
  // Freeze PC and IF/ID, inject a bubble into ID/EX (stall, STOP, drain, halt).
  localparam ctrl_t CtrlBubble = 4'b0001;
  // Taken branch: refetch from target, kill both younger instructions.
  localparam ctrl_t CtrlSquash = 4'b1111;
  // Jump in ID: the fetched slot is wrong-path, the jump itself proceeds.
  localparam ctrl_t CtrlJump   = 4'b1110;
  // Held during reset: nothing advances, both registers hold bubbles.
  localparam ctrl_t CtrlReset  = 4'b0011;

  // Instructions whose rt field is a source operand.
  function automatic logic uses_rt(input logic [5:0] op);
    return (op == OpRtype) || (op == OpBeq) || (op == OpBne) || (op == OpSw);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard controller (slave).
// Master drives the ID/EX instruction fields; slave returns register enables,
// flushes, halt status and performance counters.
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic [5:0]       id_opcode;
  logic [5:0]       id_func;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             ex_regwrite;
  logic             ex_mem2reg;
  logic [4:0]       ex_rt;
  logic             ex_branch_taken;
  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             halted;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_opcode, id_func, id_rs, id_rt,
    output ex_regwrite, ex_mem2reg, ex_rt, ex_branch_taken,
    input  pc_en, ifid_en, ifid_flush, idex_flush, halted, cycle_count, stall_count
  );

  modport slave (
    input  id_opcode, id_func, id_rs, id_rt,
    input  ex_regwrite, ex_mem2reg, ex_rt, ex_branch_taken,
    output pc_en, ifid_en, ifid_flush, idex_flush, halted, cycle_count, stall_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for performance statistics.
// Ports: clk, reset (async, active-high), inc_i (count this cycle),
//        clr_i (synchronous clear, wins over inc_i), count_o (current value).
module sat_counter #(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, taken-branch squash, jump
// redirect and the STOP drain/halt sequence, plus cycle/stall counters.
// Ports: clk, reset (async, active-high), bus (slave modport): ID/EX fields in,
//        pc_en / ifid_en / ifid_flush / idex_flush / halted / counters out.
// Control outputs are combinational from state and inputs; state is registered.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned CNT_W        = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam int unsigned DrainW = $clog2(DRAIN_CYCLES + 1);

  state_e            state_q;
  logic [DrainW-1:0] drain_cnt_q;

  logic  is_stop, is_jal_j, jump_id, load_use;
  logic  stall_inc, cycle_inc, stop_go;
  ctrl_t ctrl;

  // Hazard decode.
  always_comb begin
    is_stop  = (bus.id_opcode == OpStop);
    is_jal_j = (bus.id_opcode == OpJ) || (bus.id_opcode == OpJal);
    jump_id  = is_jal_j || ((bus.id_opcode == OpRtype) && (bus.id_func == FuncJr));
    load_use = bus.ex_regwrite && bus.ex_mem2reg && (bus.ex_rt != 5'd0) &&
               ((bus.ex_rt == bus.id_rs) ||
                (uses_rt(bus.id_opcode) && (bus.ex_rt == bus.id_rt))) &&
               !is_stop && !is_jal_j;
  end

  // Output selection by priority.
  always_comb begin
    ctrl      = CtrlBubble;
    stall_inc = 1'b0;
    stop_go   = 1'b0;
    if (reset) begin
      ctrl = CtrlReset;
    end else begin
      unique case (state_q)
        StRun: begin
          if (bus.ex_branch_taken) begin
            ctrl = CtrlSquash;
          end else if (load_use) begin
            ctrl      = CtrlBubble;
            stall_inc = 1'b1;
          end else if (is_stop) begin
            ctrl    = CtrlBubble;
            stop_go = 1'b1;
          end else if (jump_id) begin
            ctrl = CtrlJump;
          end else begin
            ctrl = CtrlRun;
          end
        end
        // A branch cannot be in EX behind a STOP, so ex_branch_taken is ignored.
        StDrain, StHalt: ctrl = CtrlBubble;
        default:         ctrl = CtrlBubble;
      endcase
    end
  end

  // The STOP cycle itself issues the first bubble, so DRAIN spans
  // DRAIN_CYCLES-1 cycles and the counter is loaded one short.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StRun;
      drain_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (stop_go) begin
            state_q     <= (DRAIN_CYCLES > 1) ? StDrain : StHalt;
            drain_cnt_q <= DrainW'(DRAIN_CYCLES - 1);
          end
        end
        StDrain: begin
          drain_cnt_q <= drain_cnt_q - DrainW'(1);
          if (drain_cnt_q <= DrainW'(1)) begin
            state_q <= StHalt;
          end
        end
        StHalt:  state_q <= StHalt;
        default: state_q <= StRun;
      endcase
    end
  end

  assign cycle_inc = !reset && (state_q != StHalt);

  sat_counter #(
    .Width (CNT_W)
  ) u_cycle_cnt (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (cycle_inc),
    .clr_i   (1'b0),
    .count_o (bus.cycle_count)
  );

  sat_counter #(
    .Width (CNT_W)
  ) u_stall_cnt (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (stall_inc),
    .clr_i   (1'b0),
    .count_o (bus.stall_count)
  );

  assign bus.pc_en      = ctrl.pc_en;
  assign bus.ifid_en    = ctrl.ifid_en;
  assign bus.ifid_flush = ctrl.ifid_flush;
  assign bus.idex_flush = ctrl.idex_flush;
  assign bus.halted     = (state_q == StHalt);

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with a queue-based scoreboard:
// the driver pushes the hand-computed response for each cycle, and a monitor
// on the falling edge pops and compares against what the DUT presents.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned CntW = 32;

  logic clk;
  logic reset;

  pipeline_hazard_ctrl_if #(.CNT_W(CntW)) bus ();

  pipeline_hazard_ctrl #(
    .DRAIN_CYCLES (4),
    .CNT_W        (CntW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    string     name;
    logic [3:0] ctl;   // {pc_en, ifid_en, ifid_flush, idex_flush}, x = don't care
    logic       halted;
    logic [CntW-1:0] cyc;
    logic [CntW-1:0] stl;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: one expectation per cycle, sampled away from the rising edge.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      logic [3:0] got;
      logic bad;
      e   = exp_q.pop_front();
      got = {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_flush};
      bad = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if ((e.ctl[i] !== 1'bx) && (got[i] !== e.ctl[i])) bad = 1'b1;
      end
      if (bus.halted !== e.halted) bad = 1'b1;
      if (bus.cycle_count !== e.cyc) bad = 1'b1;
      if (bus.stall_count !== e.stl) bad = 1'b1;
      checks = checks + 1;
      if (bad) begin
        failures = failures + 1;
        $display("FAIL %s: got ctl=%b halted=%b cyc=%0d stall=%0d, want ctl=%b halted=%b cyc=%0d stall=%0d",
                 e.name, got, bus.halted, bus.cycle_count, bus.stall_count,
                 e.ctl, e.halted, e.cyc, e.stl);
      end
    end
  end

  // Drive one cycle of inputs (at rising edge + 1) and queue its response.
  task automatic vec(input string nm, input logic rst,
                     input logic [5:0] op, input logic [5:0] fn,
                     input logic [4:0] rs, input logic [4:0] rt,
                     input logic exw, input logic exm, input logic [4:0] exrt,
                     input logic br, input logic [3:0] ctl, input logic hlt,
                     input int cyc, input int stl);
    exp_t e;
    reset               = rst;
    bus.id_opcode       = op;
    bus.id_func         = fn;
    bus.id_rs           = rs;
    bus.id_rt           = rt;
    bus.ex_regwrite     = exw;
    bus.ex_mem2reg      = exm;
    bus.ex_rt           = exrt;
    bus.ex_branch_taken = br;
    e.name   = nm;
    e.ctl    = ctl;
    e.halted = hlt;
    e.cyc    = CntW'(cyc);
    e.stl    = CntW'(stl);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, want finish before 100000");
    $fatal(1, "timeout");
  end

  initial begin
    reset               = 1'b1;
    bus.id_opcode       = '0;
    bus.id_func         = '0;
    bus.id_rs           = '0;
    bus.id_rt           = '0;
    bus.ex_regwrite     = 1'b0;
    bus.ex_mem2reg      = 1'b0;
    bus.ex_rt           = '0;
    bus.ex_branch_taken = 1'b0;
    @(posedge clk);
    #1;
    //   name          rst op     fn     rs  rt  exw exm exrt br ctl      hlt cyc stl
    vec("in_reset",    1, 6'd0,  6'd32, 1,  2,  0,  0,  0,   0, 4'b0011, 0,  0,  0);
    vec("add_plain",   0, 6'd0,  6'd32, 1,  2,  0,  0,  0,   0, 4'b1100, 0,  0,  0);
    vec("lu_rt_add",   0, 6'd0,  6'd32, 1,  5,  1,  1,  5,   0, 4'b0001, 0,  1,  0);
    vec("after_stall", 0, 6'd0,  6'd32, 1,  5,  0,  0,  0,   0, 4'b1100, 0,  2,  1);
    vec("lu_r0",       0, 6'd0,  6'd32, 0,  0,  1,  1,  0,   0, 4'b1100, 0,  3,  1);
    vec("addi_rt",     0, 6'd8,  6'd0,  1,  5,  1,  1,  5,   0, 4'b1100, 0,  4,  1);
    vec("addi_rs",     0, 6'd8,  6'd0,  5,  1,  1,  1,  5,   0, 4'b0001, 0,  5,  1);
    vec("br_over_lu",  0, 6'd0,  6'd32, 5,  1,  1,  1,  5,   1, 4'b1111, 0,  6,  2);
    vec("br_over_stp", 0, 6'd63, 6'd0,  0,  0,  0,  0,  0,   1, 4'b1111, 0,  7,  2);
    vec("jr",          0, 6'd0,  6'd8,  3,  0,  0,  0,  0,   0, 4'b1110, 0,  8,  2);
    vec("j_no_lu",     0, 6'd2,  6'd0,  5,  5,  1,  1,  5,   0, 4'b1110, 0,  9,  2);
    vec("stop",        0, 6'd63, 6'd0,  0,  0,  0,  0,  0,   0, 4'b00x1, 0,  10, 2);
    vec("drain1",      0, 6'd0,  6'd32, 1,  2,  0,  0,  0,   0, 4'b0001, 0,  11, 2);
    vec("drain2_br",   0, 6'd0,  6'd32, 1,  2,  0,  0,  0,   1, 4'b0001, 0,  12, 2);
    vec("drain3_lu",   0, 6'd0,  6'd32, 5,  5,  1,  1,  5,   0, 4'b0001, 0,  13, 2);
    vec("halt1",       0, 6'd0,  6'd32, 1,  2,  0,  0,  0,   0, 4'b0001, 1,  14, 2);
    vec("halt2",       0, 6'd0,  6'd32, 5,  5,  1,  1,  5,   0, 4'b0001, 1,  14, 2);
    vec("rst_in_halt", 1, 6'd0,  6'd32, 1,  2,  0,  0,  0,   0, 4'b0011, 0,  0,  0);
    vec("rerun",       0, 6'd0,  6'd32, 1,  2,  0,  0,  0,   0, 4'b1100, 0,  0,  0);
    vec("stop2",       0, 6'd63, 6'd0,  0,  0,  0,  0,  0,   0, 4'b00x1, 0,  1,  0);
    vec("drain_b",     0, 6'd0,  6'd32, 1,  2,  0,  0,  0,   0, 4'b0001, 0,  2,  0);
    vec("rst_in_drn",  1, 6'd0,  6'd32, 1,  2,  0,  0,  0,   0, 4'b0011, 0,  0,  0);
    vec("post_rst0",   0, 6'd0,  6'd32, 1,  2,  0,  0,  0,   0, 4'b1100, 0,  0,  0);
    vec("post_rst1",   0, 6'd0,  6'd32, 1,  2,  0,  0,  0,   0, 4'b1100, 0,  1,  0);
    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks   = checks + 1;
      failures = failures + 1;
      $display("FAIL drain_queue: got %0d pending, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
